// File: rtl/sync_fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-drain UART transmitter.
//   uart_tx_state_t    : transmitter FSM states
//   DEFAULT_DATA_WIDTH : FIFO word / serial payload width
//   frame_len()        : clock cycles occupied by one serial frame
package sync_fifo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int unsigned DEFAULT_DATA_WIDTH = 6;

    function automatic int unsigned frame_len(input int unsigned data_width,
                                              input int unsigned clks_per_bit,
                                              input int unsigned parity_en);
        return (2 + data_width + parity_en) * clks_per_bit;
    endfunction

endpackage

// File: rtl/sync_fifo_uart_tx_if.sv
// Handshake bundle between the sync FIFO / top-level pin mux and the
// UART drain stage.
//   en, fifo_dat, fifo_empty, fifo_wr_en : into the transmitter
//   fifo_rd_en, tx, busy, frame_done     : out of the transmitter
// master: FIFO / environment side, slave: transmitter side.
interface sync_fifo_uart_tx_if
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

    logic                  en;
    logic [DATA_WIDTH-1:0] fifo_dat;
    logic                  fifo_empty;
    logic                  fifo_wr_en;
    logic                  fifo_rd_en;
    logic                  tx;
    logic                  busy;
    logic                  frame_done;

    modport master (
        output en, fifo_dat, fifo_empty, fifo_wr_en,
        input  fifo_rd_en, tx, busy, frame_done
    );

    modport slave (
        input  en, fifo_dat, fifo_empty, fifo_wr_en,
        output fifo_rd_en, tx, busy, frame_done
    );

endinterface

// File: rtl/sync_fifo_uart_tx_bit_timer.sv
// Bit-time down-counter for the UART transmitter.
//   clk, rst_n : clock, asynchronous active-low reset
//   restart_i  : hold the counter at the start of a fresh bit time
//   bit_end_o  : single-cycle tick on the last cycle of each bit time
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    output logic bit_end_o
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Reaching zero both ends the bit and reloads for the next one.
    always_comb begin
        cnt_d = cnt_q - CW'(1);
        if (restart_i || (cnt_q == '0)) begin
            cnt_d = RELOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end_o = !restart_i && (cnt_q == '0);

endmodule

// File: rtl/sync_fifo_uart_tx.sv
// Drain stage behind the sync FIFO: pops one word per frame and sends it
// as start bit, data LSB first, optional even parity, stop bit.
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus.en            : permits starting a new frame
//   bus.fifo_dat      : FIFO read data, valid the cycle after an honoured pop
//   bus.fifo_empty    : FIFO empty flag
//   bus.fifo_wr_en    : upstream write strobe (a coinciding pop is dropped)
//   bus.fifo_rd_en    : pop strobe
//   bus.tx            : serial line, idle high
//   bus.busy          : frame in progress (POP through STOP)
//   bus.frame_done    : one-cycle pulse after each stop bit
module sync_fifo_uart_tx
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    sync_fifo_uart_tx_if.slave  bus
);

    localparam int unsigned IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

    uart_tx_state_t        state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  par_q, par_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  done_q, done_d;
    logic                  restart;
    logic                  bit_end;
    logic                  tx_bit;

    // The timer only runs while a bit is on the line.
    assign restart = !((state_q == START) || (state_q == DATA) ||
                       (state_q == PARITY) || (state_q == STOP));

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart_i (restart),
        .bit_end_o (bit_end)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.en && !bus.fifo_empty) state_d = POP;
            end
            POP: begin
                // The FIFO drops a read that collides with a write; retry.
                if (!bus.fifo_wr_en) state_d = LOAD;
            end
            LOAD: begin
                shreg_d = bus.fifo_dat;
                par_d   = ^bus.fifo_dat;
                idx_d   = '0;
                state_d = START;
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    done_d  = 1'b1;
                    state_d = (bus.en && !bus.fifo_empty) ? POP : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            par_q   <= 1'b0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Line level is a pure decode of registered state.
    always_comb begin
        tx_bit = 1'b1;
        unique case (state_q)
            START:   tx_bit = 1'b0;
            DATA:    tx_bit = shreg_q[0];
            PARITY:  tx_bit = par_q;
            default: tx_bit = 1'b1;
        endcase
    end

    assign bus.tx         = tx_bit;
    assign bus.fifo_rd_en = (state_q == POP);
    assign bus.busy       = (state_q != IDLE);
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_sync_fifo_uart_tx.sv
// Self-checking bench for sync_fifo_uart_tx: directed vector table for a
// single frame, hand-written corner sequences, and a randomized run
// checked against a frame-level reference model with an emulated FIFO.
module tb_sync_fifo_uart_tx;

    localparam int DW    = 6;
    localparam int CPB   = 4;
    localparam int PEN   = 1;
    localparam int FRAME = (2 + DW + PEN) * CPB;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    sync_fifo_uart_tx_if #(.DATA_WIDTH(DW)) bus();

    sync_fifo_uart_tx #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB),
        .PARITY_EN    (PEN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          ofs;
        logic [3:0]  exp;   // {tx, busy, fifo_rd_en, frame_done}
        string       name;
    } vec_t;

    vec_t        tbl[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          rd_cnt = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] wr_word;
    logic        hist[64];
    int          t0, p, h, d1, d2, viol, rc0;
    logic        d;

    function automatic void add_vec(input int o, input logic [3:0] e, input string n);
        vec_t v;
        v.ofs  = o;
        v.exp  = e;
        v.name = n;
        tbl.push_back(v);
    endfunction

    // Expected line level k cycles after the start bit begins.
    function automatic logic frame_bit(input logic [DW-1:0] w, input int k);
        int b;
        b = k / CPB;
        if (b == 0) return 1'b0;
        if (b <= DW) return w[b-1];
        if (PEN != 0 && b == DW + 1) return ^w;
        return 1'b1;
    endfunction

    function automatic logic [3:0] outs();
        return {bus.tx, bus.busy, bus.fifo_rd_en, bus.frame_done};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic load(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        bus.fifo_empty = 1'b0;
    endtask

    // One clock: FIFO emulation updates after the edge, outputs are sampled
    // on the falling edge, and every completed frame is checked bit by bit.
    task automatic cycle();
        logic          pp, pw;
        logic [DW-1:0] ww, w;
        logic [FRAME-1:0] got, want;
        pp = bus.fifo_rd_en & ~bus.fifo_wr_en;
        pw = bus.fifo_wr_en;
        ww = wr_word;
        @(negedge clk);
        if (pw) begin
            fifo_q.push_back(ww);
            exp_q.push_back(ww);
        end else if (pp && fifo_q.size() != 0) begin
            bus.fifo_dat = fifo_q.pop_front();
        end
        bus.fifo_empty = (fifo_q.size() == 0);
        cyc++;
        hist[cyc % 64] = bus.tx;
        if (bus.fifo_rd_en) rd_cnt++;
        if (bus.frame_done) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL frame_unexpected: actual frame_done=1 required 0 (cycle %0d)", cyc);
            end else begin
                w = exp_q.pop_front();
                for (int k = 0; k < FRAME; k++) begin
                    got[k]  = hist[(cyc - FRAME + k) % 64];
                    want[k] = frame_bit(w, k);
                end
                chk($sformatf("frame_%02h", w), 64'(got), 64'(want));
            end
        end
    endtask

    task automatic drain(input int n, input string nm);
        for (int i = 0; i < n && !(fifo_q.size() == 0 && exp_q.size() == 0 && !bus.busy); i++)
            cycle();
        chk(nm, 64'(fifo_q.size() == 0 && exp_q.size() == 0 && !bus.busy), 64'd1);
    endtask

    initial begin
        bus.en         = 1'b1;
        bus.fifo_wr_en = 1'b0;
        bus.fifo_dat   = '0;
        bus.fifo_empty = 1'b1;
        wr_word        = '0;

        // Single frame of 6'h2D relative to the honoured pop cycle.
        add_vec( 0, 4'b1110, "pop");
        add_vec( 1, 4'b1100, "load");
        add_vec( 2, 4'b0100, "start_first");
        add_vec( 5, 4'b0100, "start_last");
        add_vec( 6, 4'b1100, "d0");
        add_vec( 9, 4'b1100, "d0_last");
        add_vec(10, 4'b0100, "d1");
        add_vec(14, 4'b1100, "d2");
        add_vec(18, 4'b1100, "d3");
        add_vec(22, 4'b0100, "d4");
        add_vec(26, 4'b1100, "d5");
        add_vec(29, 4'b1100, "d5_last");
        add_vec(30, 4'b0100, "parity");
        add_vec(33, 4'b0100, "parity_last");
        add_vec(34, 4'b1100, "stop");
        add_vec(37, 4'b1100, "stop_last");
        add_vec(38, 4'b1001, "done");
        add_vec(39, 4'b1000, "idle");

        // Reset with a word waiting and en high.
        #1 rst_n = 1'b0;
        load(6'h2D);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst_outs", 64'(outs()), 64'(4'b1000));
        end
        rst_n = 1'b1;
        cycle();
        t0 = cyc;
        foreach (tbl[i]) begin
            while (cyc < t0 + tbl[i].ofs) cycle();
            chk(tbl[i].name, 64'(outs()), 64'(tbl[i].exp));
        end

        // Write collision during POP, en dropped so only one frame goes out.
        rc0 = rd_cnt;
        load(6'h15);
        cycle();
        p = cyc;
        chk("coll_pop", 64'(bus.fifo_rd_en), 64'd1);
        bus.en         = 1'b0;
        bus.fifo_wr_en = 1'b1;
        wr_word        = 6'h0A;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("coll_rd_hold", 64'({bus.fifo_rd_en, bus.busy}), 64'(2'b11));
        end
        bus.fifo_wr_en = 1'b0;
        cycle();
        chk("coll_load", 64'(outs()), 64'(4'b1100));
        h = p + 3;
        while (cyc < h + 2) cycle();
        chk("coll_start", 64'(bus.tx), 64'd0);
        while (cyc < h + 30) cycle();
        chk("coll_parity", 64'(bus.tx), 64'd1);
        while (cyc < h + 38) cycle();
        chk("coll_done", 64'(bus.frame_done), 64'd1);
        viol = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (bus.fifo_rd_en || bus.busy || !bus.tx) viol++;
        end
        chk("en_low_idle", 64'(viol), 64'd0);
        chk("coll_rd_cycles", 64'(rd_cnt - rc0), 64'd4);

        // en dropped mid-frame with the FIFO still non-empty.
        bus.en = 1'b1;
        cycle();
        chk("drop_pop", 64'(bus.fifo_rd_en), 64'd1);
        repeat (10) cycle();
        bus.en = 1'b0;
        d = 1'b0;
        for (int i = 0; i < 60 && !d; i++) begin
            cycle();
            d = bus.frame_done;
        end
        chk("drop_done", 64'(d), 64'd1);
        viol = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (bus.fifo_rd_en || bus.busy || !bus.tx) viol++;
        end
        chk("drop_idle", 64'(viol), 64'd0);
        bus.en = 1'b1;
        cycle();
        chk("resume_pop", 64'(bus.fifo_rd_en), 64'd1);
        drain(400, "drain_resume");

        // Back-to-back frames.
        load(6'h3F);
        load(6'h00);
        cycle();
        p = cyc;
        chk("b2b_pop1", 64'(bus.fifo_rd_en), 64'd1);
        d1 = -1;
        d2 = -1;
        for (int i = 0; i < 120 && d2 < 0; i++) begin
            cycle();
            if (bus.frame_done) begin
                if (d1 < 0) d1 = cyc;
                else        d2 = cyc;
            end
            if (cyc == p + 38) chk("b2b_pop2", 64'({bus.busy, bus.fifo_rd_en}), 64'(2'b11));
            if (cyc == p + 39) chk("b2b_load_high", 64'(bus.tx), 64'd1);
            if (cyc == p + 40) chk("b2b_start2", 64'(bus.tx), 64'd0);
        end
        chk("b2b_done1", 64'(d1), 64'(p + 38));
        chk("b2b_spacing", 64'(d2 - d1), 64'd38);
        drain(10, "drain_b2b");

        // Asynchronous reset in the middle of the data bits.
        load(6'h2B);
        load(6'h33);
        cycle();
        p = cyc;
        while (cyc < p + 15) cycle();
        chk("pre_abort", 64'({bus.tx, bus.busy}), 64'(2'b01));
        #1 rst_n = 1'b0;
        #1 chk("abort_async", 64'(outs()), 64'(4'b1000));
        void'(exp_q.pop_front());
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("post_reset_pop", 64'({bus.fifo_rd_en, bus.busy}), 64'(2'b11));
        drain(80, "drain_abort");

        // Randomized writes and en toggling.
        bus.en = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 15) == 0) bus.en = ~bus.en;
            bus.fifo_wr_en = ($urandom_range(0, 39) == 0);
            wr_word        = DW'($urandom);
            cycle();
        end
        bus.en         = 1'b1;
        bus.fifo_wr_en = 1'b0;
        drain(5000, "drain_random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_uart_tx.md
Name: sync_fifo_uart_tx

Overview:
Drain stage directly downstream of the 6-bit sync FIFO tile. Pops one word at a time from the FIFO, frames it (start, data LSB-first, optional even parity, stop) and shifts it out on a single serial line at a fixed clocks-per-bit rate. Presents busy and frame-done status for the top-level pin mux.

Parameters:
DATA_WIDTH, 6, width of the FIFO word and of the serial payload
CLKS_PER_BIT, 4, clock cycles per serial bit; legal range >= 1
PARITY_EN, 1, 1 = append an even-parity bit after the data; 0 = no parity bit

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
en  input  1  permits starting a new frame; sampled only when no frame is in progress
fifo_dat  input  DATA_WIDTH  FIFO registered read data, valid the cycle after an honoured pop
fifo_empty  input  1  FIFO empty flag
fifo_wr_en  input  1  upstream write strobe into the FIFO (a write takes priority there)
fifo_rd_en  output  1  pop strobe to the FIFO
tx  output  1  serial line, idle high
busy  output  1  high while a frame is in progress (POP through STOP)
frame_done  output  1  one-cycle pulse after each stop bit completes

Behaviour:
- Reset: asynchronous and active-low on rst_n. While rst_n is low, all outputs are forced immediately: tx=1, fifo_rd_en=0, busy=0, frame_done=0. Internally, state=IDLE and all counters are cleared.
- Reset mid-frame: the frame is aborted and tx returns high at once. The popped word is lost; no resume.
- All outputs are registered or Moore. No combinational path runs from any input to any output.
- States:
  - IDLE: tx=1. Go to POP when en=1 and fifo_empty=0.
  - POP: fifo_rd_en=1. Go to LOAD when fifo_wr_en=0 in the same cycle; otherwise stay in POP. The FIFO drops a read that coincides with a write.
  - LOAD: capture fifo_dat into the shift register and compute parity as the XOR of the data bits. Go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: DATA_WIDTH bits, LSB first, each CLKS_PER_BIT cycles.
  - PARITY: entered only when PARITY_EN=1. tx=parity for CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On completion, go to POP if en=1 and fifo_empty=0, else to IDLE.
- Frame length: (2 + DATA_WIDTH + PARITY_EN) * CLKS_PER_BIT cycles. With the defaults that is 36 cycles.
- Latency: tx falls 2 cycles after the first honoured POP cycle.
- Pulse rules:
  - frame_done is high for exactly one cycle: the first cycle after STOP, whether that cycle is IDLE or POP.
  - fifo_rd_en is high for exactly the number of POP cycles; one honoured pop per frame.
- Boundary conditions:
  - en falling mid-frame: the frame completes, and no new frame starts.
  - fifo_empty changes mid-frame: ignored.
  - Back-to-back frames: no idle-high gap beyond the STOP bit plus the 2 cycles of POP and LOAD.
- Counter widths:
  - Bit-time counter: $clog2(CLKS_PER_BIT) bits, minimum 1. It counts 0..CLKS_PER_BIT-1 and the terminal value advances the bit.
  - Bit index: $clog2(DATA_WIDTH) bits, minimum 1. The shift register shifts right once per data bit.

Decomposition:
- Package sync_fifo_pkg holds:
  - the uart_tx_state_t enum (IDLE, POP, LOAD, START, DATA, PARITY, STOP);
  - the default DATA_WIDTH;
  - a localparam function for frame length.
- Sub-module uart_bit_timer: the CLKS_PER_BIT down-counter with an async reset and a restart input. It outputs a single-cycle bit_end tick.
- The FSM, shift register and parity logic stay in sync_fifo_uart_tx.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with en=1 and fifo_empty=0. Expect tx=1, busy=0 and fifo_rd_en=0 throughout. Release rst_n, and the first POP occurs on the next edge.
- Single frame with defaults: fifo_dat=6'h2D, pop honoured at cycle T.
  - Expect tx low over T+2..T+5.
  - Then data bits 1,0,1,1,0,1, each 4 cycles, over T+6..T+29.
  - Then parity 0 over T+30..T+33 and stop 1 over T+34..T+37.
  - Expect frame_done=1 only at T+38.
- Write collision: hold fifo_wr_en=1 for 3 cycles during POP. Expect fifo_rd_en high for 4 cycles, LOAD only after fifo_wr_en drops, and exactly one frame sent.
- Back-to-back: queue 6'h3F then 6'h00 with en held high.
  - First frame: parity 0.
  - Second frame: parity 0, and tx low 2 cycles after the first stop bit ends.
  - Expect two frame_done pulses 38 cycles apart.
- en dropped mid-frame (fifo still non-empty): the current frame completes, then IDLE with tx=1. Expect no further fifo_rd_en until en=1.
- Async reset mid-data (cycle T+15): tx=1 and busy=0 immediately, with no clock edge needed. After release, a fresh frame starts from POP if the FIFO is non-empty.
